// File: rtl/aes_result_tx_pkg.sv
// Shared definitions for the AES result transmitter: FSM state encodings,
// RAM block layout constants and default timing parameters.
// Optional feature macro: AES_RESULT_TX_PARITY_EN (even parity bit per frame).
package aes_result_tx_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_POLL_REQ  = 4'd1,
    S_POLL_WAIT = 4'd2,
    S_POLL_CHK  = 4'd3,
    S_RD_REQ    = 4'd4,
    S_RD_WAIT   = 4'd5,
    S_RD_CAP    = 4'd6,
    S_TX_LOAD   = 4'd7,
    S_TX_WAIT   = 4'd8,
    S_DONE      = 4'd9,
    S_ERR       = 4'd10
  } state_e;

  // Block k occupies RAM addresses 10k+1 .. 10k+10.
  localparam logic [6:0]  BLK_WORDS  = 7'd10;
  localparam logic [6:0]  MARKER_OFS = 7'd10;
  localparam logic [6:0]  CIPHER_OFS = 7'd6;
  localparam logic [31:0] MARKER_VAL = 32'hFFFF_FFFF;
  // Highest block index whose marker still fits in the 7-bit address space.
  localparam logic [3:0]  MAX_BLK    = 4'd11;

  localparam int CLKS_PER_BIT_DEF = 434;   // 50 MHz / 115200 baud
  localparam int POLL_MAX_DEF     = 1023;

  // First address of block k minus one (10k).
  function automatic logic [6:0] blk_base(input logic [3:0] k);
    return {3'b000, k} * BLK_WORDS;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One-byte UART transmitter: start bit, 8 data bits LSB first, optional even
// parity, stop bit. Each bit lasts CLKS_PER_BIT cycles. tx_done is high during
// the last cycle of the stop bit so the next byte can start one cycle later.
// Optional feature macro: AES_RESULT_TX_PARITY_EN.
module uart_tx_byte
  import aes_result_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done
);

`ifdef AES_RESULT_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam int CW = $clog2(FRAME_BITS);

  // Frame shifts right; bit 0 is the bit currently on the line.
  logic                  active_q, active_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [CW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] frame_new;
  logic                  bit_end;

  // Assemble the frame to send, LSB first on the wire.
  always_comb begin
`ifdef AES_RESULT_TX_PARITY_EN
    frame_new = {1'b1, ^tx_data, tx_data, 1'b0};
`else
    frame_new = {1'b1, tx_data, 1'b0};
`endif
  end

  assign bit_end = active_q && (baud_q == BW'(CLKS_PER_BIT - 1));
  assign tx_done = bit_end && (bit_q == CW'(FRAME_BITS - 1));
  assign tx      = frame_q[0];

  // Baud and bit counting; idle frame is all ones so tx idles high.
  always_comb begin
    active_d = active_q;
    frame_d  = frame_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    if (!active_q) begin
      if (tx_start) begin
        active_d = 1'b1;
        frame_d  = frame_new;
        baud_d   = '0;
        bit_d    = '0;
      end
    end else if (bit_end) begin
      baud_d = '0;
      if (tx_done) begin
        active_d = 1'b0;
        frame_d  = '1;
      end else begin
        bit_d   = bit_q + 1'b1;
        frame_d = {1'b1, frame_q[FRAME_BITS-1:1]};
      end
    end else begin
      baud_d = baud_q + 1'b1;
    end
  end

  // State registers; reset aborts any frame and returns the line high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      frame_q  <= '1;
      baud_q   <= '0;
      bit_q    <= '0;
    end else begin
      active_q <= active_d;
      frame_q  <= frame_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
    end
  end

endmodule

// File: rtl/aes_result_tx.sv
// AES result readback/transmit: polls the completion marker of block k in the
// 128x32 RAM, reads the four ciphertext words (highest address first) and sends
// them MSB byte first as 16 UART frames.
// Optional feature macro: AES_RESULT_TX_PARITY_EN (passed to uart_tx_byte).
module aes_result_tx
  import aes_result_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int POLL_MAX     = POLL_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  blk,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ram_en,
  output logic        ram_action,
  output logic [6:0]  ram_addr,
  input  logic [31:0] ram_data,
  output logic        tx
);

  localparam int PW = (POLL_MAX < 1) ? 1 : $clog2(POLL_MAX + 1);

  state_e        state_q, state_d;
  logic [3:0]    blk_q, blk_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [1:0]    w_q, w_d;
  logic [1:0]    b_q, b_d;
  logic [31:0]   word_q, word_d;
  logic          tx_start;
  logic          tx_done;
  logic [7:0]    tx_data;

  assign ram_action = 1'b0;
  assign tx_data    = word_q[{b_q, 3'b000} +: 8];

  // Next-state and outputs; outputs decode from state alone.
  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    poll_d   = poll_q;
    w_d      = w_q;
    b_d      = b_q;
    word_d   = word_q;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    ram_en   = 1'b0;
    ram_addr = '0;
    tx_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          blk_d   = blk;
          poll_d  = '0;
          state_d = (blk > MAX_BLK) ? S_ERR : S_POLL_REQ;
        end
      end
      S_POLL_REQ: begin
        busy     = 1'b1;
        ram_en   = 1'b1;
        ram_addr = blk_base(blk_q) + MARKER_OFS;
        state_d  = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        busy    = 1'b1;
        state_d = S_POLL_CHK;
      end
      S_POLL_CHK: begin
        busy = 1'b1;
        if (ram_data == MARKER_VAL) begin
          w_d     = 2'd3;
          state_d = S_RD_REQ;
        end else if (poll_q == PW'(POLL_MAX)) begin
          state_d = S_ERR;
        end else begin
          poll_d  = poll_q + 1'b1;
          state_d = S_POLL_REQ;
        end
      end
      S_RD_REQ: begin
        busy     = 1'b1;
        ram_en   = 1'b1;
        ram_addr = blk_base(blk_q) + CIPHER_OFS + {5'b00000, w_q};
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        busy    = 1'b1;
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        busy    = 1'b1;
        word_d  = ram_data;
        b_d     = 2'd3;
        state_d = S_TX_LOAD;
      end
      S_TX_LOAD: begin
        busy     = 1'b1;
        tx_start = 1'b1;
        state_d  = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        busy = 1'b1;
        if (tx_done) begin
          if (b_q != 2'd0) begin
            b_d     = b_q - 1'b1;
            state_d = S_TX_LOAD;
          end else if (w_q != 2'd0) begin
            w_d     = w_q - 1'b1;
            state_d = S_RD_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      poll_q  <= '0;
      w_q     <= '0;
      b_q     <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      poll_q  <= poll_d;
      w_q     <= w_d;
      b_q     <= b_d;
      word_q  <= word_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx      (tx),
    .tx_done (tx_done)
  );

endmodule

// File: doc/aes_result_tx.md
Name: aes_result_tx

Overview:
- Readback/transmit side of the RS-232 AES path.
- After the host writes a 128-bit plaintext block into the 128x32 RAM, the AES engine writes the ciphertext and a completion marker back into that RAM. This block polls for the marker, reads the four ciphertext words and serializes them as 16 bytes on the UART TX line (8N1).
- Sits between the RAM's read port and the TX pin.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200).
- POLL_MAX, 1023, maximum marker polls before an error is reported.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: synchronous, active-low
- start  in  1  one-cycle request pulse; sampled only in IDLE
- blk  in  4  block index k; the block occupies RAM addresses 10k+1 to 10k+10
- busy  out  1  high from the accepted start until done/err
- done  out  1  one-cycle pulse after the last stop bit
- err  out  1  one-cycle pulse on a bad blk or a poll timeout
- ram_en  out  1  RAM enable
- ram_action  out  1  RAM direction; tied to 0 (read)
- ram_addr  out  7  RAM address
- ram_data  in  32  RAM read data; registered, valid on the second edge after ram_en
- tx  out  1  UART serial output; idles high

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - state IDLE; tx=1; busy=0; done=0; err=0; ram_en=0; ram_addr=0; all counters 0.
  - Reset mid-frame aborts the byte immediately; tx returns high with no partial stop bit.
- Address map for block k:
  - marker M=10k+10; expected value 32'hFFFFFFFF.
  - ciphertext words: 10k+9 holds bits [127:96], 10k+8 holds [95:64], 10k+7 holds [63:32], 10k+6 holds [31:0].
  - None of these reads hit an address that is 5 mod 10, so reads never trigger AES.
- Valid k is 0 to 11. For k>11 (M>127): no RAM access; err pulses 1 cycle after start; return to IDLE.
- States and transitions:
  - IDLE: on start, latch blk, set busy=1, clear poll_cnt, go to POLL_REQ.
  - POLL_REQ: ram_en=1, ram_addr=M for 1 cycle, then POLL_WAIT.
  - POLL_WAIT: ram_en=0 for 1 cycle, then POLL_CHK.
  - POLL_CHK:
    - ram_data==FFFFFFFF: set word index w=3, go to RD_REQ.
    - otherwise, if poll_cnt==POLL_MAX: err pulse, busy=0, go to IDLE.
    - otherwise: poll_cnt+1, go to POLL_REQ.
  - RD_REQ: ram_en=1, ram_addr=10k+6+w. Then RD_WAIT, then RD_CAP.
  - RD_CAP: shift register <= ram_data; byte index b=3; go to TX_LOAD.
  - TX_LOAD: pulse tx_start to the sub-module with byte [8b+7:8b], i.e. MSB byte first.
  - TX_WAIT: on tx_done, either b-1 and go to TX_LOAD, or, if b==0:
    - w>0: w-1, go to RD_REQ.
    - w==0: go to DONE.
  - DONE: done=1 for 1 cycle, busy=0, go to IDLE.
- Byte order on the wire: word 10k+9 bits [31:24] first; word 10k+6 bits [7:0] last. 16 bytes total.
- start while busy is ignored; no queueing.
- Each UART frame: start bit 0, data bits 0 to 7 LSB first, stop bit 1. Every bit lasts exactly CLKS_PER_BIT cycles.
- Consecutive bytes are back-to-back: the next start bit begins 1 cycle after the stop bit ends. That gap is accepted.
- The block does not clear the marker; the host overwrites the RAM before reuse.

Optional Feature:
- Macro: AES_RESULT_TX_PARITY_EN.
- Defined: each frame carries an even-parity bit (XOR of the data bits) between data bit 7 and the stop bit. Frame is 11 bits.
- Undefined: 8N1, 10-bit frame.

Decomposition:
- Shared include file `rs232_defs.vh` holds:
  - state encodings;
  - BLK_WORDS=10, MARKER_OFS=10, CIPHER_OFS=6, MARKER_VAL=32'hFFFFFFFF;
  - default CLKS_PER_BIT.
- One sub-module, uart_tx_byte:
  - ports: clk, rst_n, tx_start, tx_data[7:0], tx, tx_done;
  - contains the baud counter, bit counter and the PARITY_EN logic.
- The top level holds the FSM, poll counter, word/byte indices and the RAM interface.

Test Plan:
- Preload RAM[6..9]=01234567, 89ABCDEF, DEADBEEF, 0BADF00D and RAM[10]=FFFFFFFF; start with blk=0 -> TX bytes 0B AD F0 0D DE AD BE EF 89 AB CD EF 01 23 45 67; one done pulse; busy falls the same cycle done is seen.
- RAM[20]=0 for the first 5 polls, then FFFFFFFF; blk=1 -> exactly 6 marker reads at addr 20, then reads at 19, 18, 17, 16; 16 bytes sent.
- blk=12 -> err pulse 1 cycle after start; ram_en never asserted; tx stays high.
- Marker never set, POLL_MAX=3 -> 4 reads at M, then err; done never pulses.
- rst_n=0 asserted during byte 5 -> next edge: tx=1, busy=0, ram_en=0; a new start with blk=0 replays all 16 bytes correctly.
- With PARITY_EN and byte 0x0B -> frame 0, 1101 0000, parity 1, stop 1; each bit lasts CLKS_PER_BIT cycles, checked by a cycle counter.
